// File: rtl/pycmpgen_pkg.sv
// Shared definitions for the compressor-generator result path.
// Holds the serializer FSM state type, the default frame geometry and a
// helper that sizes counters so they can hold their terminal value.
package pycmpgen_pkg;

  // Default number of result bits per frame and the settle delay.
  // The settle delay is the number of clocks the upstream shift chains
  // need to fill before dst is meaningful.
  localparam int DEF_WIDTH  = 49;
  localparam int DEF_SETTLE = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } ser_state_e;

  // Width of a counter that must represent 0..n without wrapping.
  // Always at least one bit so a zero-length count still has a register.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/result_serializer.sv
// result_serializer
// Captures a WIDTH-bit compressor result after a fixed settle delay and
// streams it out LSB first over a valid/ready serial handshake.
//
// Ports
//   clk         rising-edge clock shared with the shift_register harness
//   rst_n       synchronous active-low reset
//   start       capture/serialize request, only looked at in IDLE
//   dst         compressor result bits, sampled only at the capture edge
//   busy        high whenever the FSM is not IDLE
//   sout        current serial bit (dst[0] first)
//   sout_valid  sout holds a bit the sink may take
//   sout_ready  sink accepts sout this cycle
//   sout_last   marks bit WIDTH-1
//   done        one-cycle pulse after the last bit is accepted
//
// All outputs are registered: they are computed from next-state values
// and captured alongside the state, so nothing combinational reaches a
// port.
module result_serializer
  import pycmpgen_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dst,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int SW = cnt_w(SETTLE);

  localparam logic [BW-1:0] LAST_IDX  = BW'(WIDTH - 1);
  // The settle counter counts down to zero, so it is loaded with
  // SETTLE-1: capture then lands exactly SETTLE edges after start.
  localparam logic [SW-1:0] SETTLE_LD = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

  ser_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic busy_q, busy_d;
  logic sout_q, sout_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic done_q, done_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (SETTLE == 0) begin
            // No settle time: capture on the same edge start is seen.
            shreg_d = dst;
            bit_d   = '0;
            state_d = S_SHIFT;
          end else begin
            settle_d = SETTLE_LD;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (settle_q == '0) begin
          shreg_d = dst;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_SHIFT: begin
        // Advance only on an accepted bit; a stall leaves shreg and the
        // counter alone so sout/sout_last stay put.
        if (valid_q && sout_ready) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_SHIFT);
    sout_d  = valid_d & shreg_d[0];
    last_d  = valid_d && (bit_d == LAST_IDX);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      busy_q   <= busy_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer. Two instances share clock, reset,
// dst and ready: one with SETTLE=24, one with SETTLE=0. A select bit
// routes start to one instance and picks which outputs are observed.
// Inputs are driven and outputs sampled on the falling edge.
module tb_result_serializer;

  localparam int W = 49;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [W-1:0] dst = '0;
  logic         ready = 1'b0;

  logic busy_a, sout_a, valid_a, last_a, done_a;
  logic busy_b, sout_b, valid_b, last_b, done_b;
  logic busy, sout, valid, last, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_serializer #(.WIDTH(W), .SETTLE(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .dst(dst),
    .busy(busy_a), .sout(sout_a), .sout_valid(valid_a),
    .sout_ready(ready), .sout_last(last_a), .done(done_a)
  );

  result_serializer #(.WIDTH(W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .dst(dst),
    .busy(busy_b), .sout(sout_b), .sout_valid(valid_b),
    .sout_ready(ready), .sout_last(last_b), .done(done_b)
  );

  assign busy  = sel ? busy_b  : busy_a;
  assign sout  = sel ? sout_b  : sout_a;
  assign valid = sel ? valid_b : valid_a;
  assign last  = sel ? last_b  : last_a;
  assign done  = sel ? done_b  : done_a;

  typedef struct {
    string        name;
    logic         sel;      // 1: SETTLE=0 instance
    logic [W-1:0] dst;
    int           mode;     // 0: ready always 1, 1: ready 1-0-1-0
    logic         restart;  // re-pulse start in WAIT and SHIFT
    logic         chg;      // scramble dst after capture
    int           exp_lat;  // edges from start edge to capture edge
    logic [W-1:0] exp;      // expected serialized frame
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame from start pulse to the cycle after done.
  task automatic run_frame(input vec_t v);
    int k, n, c, lastcnt, lastpos, guard;
    logic r, stalled, psout, plast, pulsed;
    logic [W-1:0] got;
    sel = v.sel; dst = v.dst; ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1;
    chk({v.name, " busy_after_start"}, 64'(busy), 64'd1);
    while (!valid && k < 100) begin
      start = (v.restart && k == 5);
      @(negedge clk); k++;
    end
    start = 1'b0;
    chk({v.name, " latency"}, 64'(k - 1), 64'(v.exp_lat));
    if (v.chg) dst = ~v.dst;
    n = 0; c = 0; lastcnt = 0; lastpos = -1; guard = 0;
    stalled = 1'b0; psout = 1'b0; plast = 1'b0; pulsed = 1'b0; got = '0;
    while (n < W && guard < 500) begin
      if (!valid || done) begin
        chk({v.name, " valid_in_frame"}, {62'd0, valid, done}, 64'd2);
      end
      if (stalled) begin
        chk({v.name, " stall_hold"}, {62'd0, sout, last}, {62'd0, psout, plast});
      end
      if (v.restart && n == 10 && !pulsed) begin
        start = 1'b1; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      r = (v.mode == 0) ? 1'b1 : (c % 2 == 0);
      ready = r;
      if (r && valid) begin
        got[n] = sout;
        if (last) begin lastcnt++; lastpos = n; end
        n++;
      end
      stalled = valid && !r; psout = sout; plast = last;
      c++; guard++;
      @(negedge clk);
    end
    ready = 1'b0; start = 1'b0;
    chk({v.name, " no_timeout"}, 64'(guard < 500), 64'd1);
    chk({v.name, " frame"}, 64'(got), 64'(v.exp));
    chk({v.name, " last_count"}, 64'(lastcnt), 64'd1);
    chk({v.name, " last_pos"}, 64'(lastpos), 64'(W - 1));
    chk({v.name, " done_pulse"}, {62'd0, done, valid}, 64'd2);
    @(negedge clk);
    chk({v.name, " after_done"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{"ends", 1'b0, 49'h1_0000_0000_0001, 0, 1'b0, 1'b0, 24, 49'h1_0000_0000_0001};
    vecs[1] = '{"alt_stall", 1'b0, 49'h0_AAAA_AAAA_AAAA, 1, 1'b0, 1'b0, 24, 49'h0_AAAA_AAAA_AAAA};
    vecs[2] = '{"restart", 1'b0, 49'h1_2345_6789_ABCD, 0, 1'b1, 1'b0, 24, 49'h1_2345_6789_ABCD};
    vecs[3] = '{"dst_change", 1'b0, 49'h0_F0F0_1234_5678, 1, 1'b0, 1'b1, 24, 49'h0_F0F0_1234_5678};
    vecs[4] = '{"settle0", 1'b1, 49'h0_0000_0000_0001, 0, 1'b0, 1'b0, 0, 49'h0_0000_0000_0001};
    vecs[5] = '{"settle0_ones", 1'b1, 49'h1_FFFF_FFFF_FFFF, 1, 1'b1, 1'b1, 0, 49'h1_FFFF_FFFF_FFFF};

    // Reset state of both instances.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", {59'd0, busy_a, sout_a, valid_a, last_a, done_a}, 64'd0);
    chk("reset_b", {59'd0, busy_b, sout_b, valid_b, last_b, done_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset for one cycle while bit 20 is on the line.
    begin
      int n, guard, dn;
      sel = 1'b0; dst = 49'h1_5555_0000_FFFF; ready = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      guard = 0;
      while (!valid && guard < 100) begin @(negedge clk); guard++; end
      chk("rst_mid valid_seen", 64'(valid), 64'd1);
      n = 0;
      ready = 1'b1;
      while (n < 20) begin @(negedge clk); n++; end
      ready = 1'b0;
      chk("rst_mid in_shift", {62'd0, busy, valid}, 64'd3);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("rst_mid outputs", {59'd0, busy, sout, valid, last, done}, 64'd0);
      dn = 0;
      ready = 1'b1;
      repeat (40) begin @(negedge clk); if (done || busy) dn++; end
      ready = 1'b0;
      chk("rst_mid no_done", 64'(dn), 64'd0);
      run_frame('{"after_rst", 1'b0, 49'h1_5555_0000_FFFF, 0, 1'b0, 1'b0, 24, 49'h1_5555_0000_FFFF});
    end

    // start while done is high is ignored; start in the next IDLE cycle is taken.
    begin
      int guard;
      sel = 1'b1; dst = 49'h0_0000_0000_0003; ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin @(negedge clk); guard++; end
      chk("b2b first_done", 64'(done), 64'd1);
      start = 1'b1;
      @(negedge clk);
      chk("b2b ignored_in_done", {62'd0, busy, done}, 64'd0);
      @(negedge clk); start = 1'b0;
      chk("b2b accepted", {62'd0, busy, valid}, 64'd3);
      chk("b2b first_bit", 64'(sout), 64'd1);
      guard = 0;
      while (!done && guard < 200) begin @(negedge clk); guard++; end
      chk("b2b second_done", 64'(done), 64'd1);
      ready = 1'b0;
      @(negedge clk);
      chk("b2b idle", {62'd0, busy, done}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
